data_ram_bytelane: RTL and testbench

- Next-generation data memory for the CPU datapath. Byte-oriented, little-endian storage, with a parametrised word width and depth.
- Adds per-byte write enables, a request/response handshake and out-of-range error reporting.
- Self-clears the whole array after reset, and again on command.
- Sits between the load/store unit and the data address space, replacing the fixed 16-bit, 64-byte data RAM.

---
 rtl/data_ram_bytelane_pkg.sv | 30 +++
 rtl/data_ram_bytelane_byte_array.sv | 64 ++++++
 rtl/data_ram_bytelane.sv | 153 +++++++++++++++
 tb/tb_data_ram_bytelane.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_bytelane_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_bytelane_pkg
// Shared definitions for the byte-lane data RAM:
//   - default bus widths
//   - controller state encoding (CLEAR / RUN)
//   - clog2 helper used to size the byte index and the clear pointer
// ---------------------------------------------------------------------------
package data_ram_bytelane_pkg;

    localparam int DEFAULT_DATA_BUS_WIDTH    = 16;
    localparam int DEFAULT_ADDRESS_BUS_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_ram_bytelane_byte_array.sv
// ---------------------------------------------------------------------------
// data_ram_bytelane_byte_array
// Byte-wide storage with BYTES_PER_WORD write ports at consecutive byte
// addresses (i_base + lane) and a registered full-word read from the same
// consecutive addresses. Storage itself has no reset; the owner clears it.
//
// Ports:
//   clk        system clock
//   rst_n      async active-low reset (read data register only)
//   i_wr_en    per-lane write enable
//   i_base     byte index of lane 0
//   i_wr_data  lane i = bits [8i+7:8i]
//   i_rd_en    capture the addressed word into o_rd_data
//   o_rd_data  registered read word; holds between reads
// ---------------------------------------------------------------------------
module data_ram_bytelane_byte_array #(
    parameter int NUM_BYTES      = 64,
    parameter int BYTES_PER_WORD = 2,
    parameter int IDX_W          = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BYTES_PER_WORD-1:0]     i_wr_en,
    input  logic [IDX_W-1:0]              i_base,
    input  logic [8*BYTES_PER_WORD-1:0]   i_wr_data,
    input  logic                          i_rd_en,
    output logic [8*BYTES_PER_WORD-1:0]   o_rd_data
);

    logic [7:0]                  r_mem [NUM_BYTES];
    logic [8*BYTES_PER_WORD-1:0] r_rd_data;
    logic [IDX_W-1:0]            w_idx [BYTES_PER_WORD];
    logic [8*BYTES_PER_WORD-1:0] w_rd_word;

    // Per-lane byte index and little-endian word assembly from the array.
    always_comb begin
        w_rd_word = {(8*BYTES_PER_WORD){1'b0}};
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            w_idx[i]          = i_base + IDX_W'(i);
            w_rd_word[8*i +: 8] = r_mem[w_idx[i]];
        end
    end

    // Byte-lane writes; each lane targets its own consecutive byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i_wr_en[i]) begin
                r_mem[w_idx[i]] <= i_wr_data[8*i +: 8];
            end
        end
    end

    // Registered read word, held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= {(8*BYTES_PER_WORD){1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= w_rd_word;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/data_ram_bytelane.sv
// ---------------------------------------------------------------------------
// data_ram_bytelane
// Byte-oriented little-endian data RAM with per-byte write enables, a
// request/response handshake, out-of-range error reporting and a self-clear
// of the whole array after reset and on clear_req.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   clear_req        pulse: restart the array clear
//   req_valid        request present; accepted when req_ready is 1
//   req_ready        1 in RUN, 0 while clearing
//   read_not_write   1 = read, 0 = write
//   address          byte address of lane 0 (any alignment)
//   byte_en          write lane enables (ignored for reads)
//   write_data       write word, lane i = bits [8i+7:8i]
//   rsp_valid        one-cycle acknowledge of an accepted request
//   rsp_err          qualifies rsp_valid: out-of-range access
//   read_data        read result, holds between reads
//   busy             clear in progress
// ---------------------------------------------------------------------------
module data_ram_bytelane
    import data_ram_bytelane_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = DEFAULT_DATA_BUS_WIDTH,
    parameter int ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH,
    parameter int NUM_BYTES         = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_req,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          read_not_write,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  address,
    input  logic [DATA_BUS_WIDTH/8-1:0]   byte_en,
    input  logic [DATA_BUS_WIDTH-1:0]     write_data,
    output logic                          rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_BUS_WIDTH-1:0]     read_data,
    output logic                          busy
);

    localparam int BYTES_PER_WORD = DATA_BUS_WIDTH / 8;
    localparam int IDX_W          = (clog2(NUM_BYTES) < 1) ? 1 : clog2(NUM_BYTES);
    localparam int PTR_W          = clog2(NUM_BYTES) + 1;
    localparam int AW1            = ADDRESS_BUS_WIDTH + 1;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_BYTES - BYTES_PER_WORD);
    localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(BYTES_PER_WORD);
    localparam logic [AW1-1:0]   LAST_BYTE = AW1'(NUM_BYTES - 1);
    localparam logic [AW1-1:0]   WORD_SPAN = AW1'(BYTES_PER_WORD - 1);

    state_e                     r_state;
    logic [PTR_W-1:0]           r_ptr;
    logic                       r_req_ready;
    logic                       r_busy;
    logic                       r_rsp_valid;
    logic                       r_rsp_err;

    logic [AW1-1:0]             w_last_addr;
    logic                       w_err;
    logic                       w_accept;
    logic                       w_rd_en;
    logic [BYTES_PER_WORD-1:0]  w_wr_en;
    logic [IDX_W-1:0]           w_base;
    logic [DATA_BUS_WIDTH-1:0]  w_wr_data;

    // Range check, acceptance and array port steering (clear vs. request).
    always_comb begin
        // One extra bit so an address near the top of the bus cannot wrap.
        w_last_addr = {1'b0, address} + WORD_SPAN;
        w_err       = (w_last_addr > LAST_BYTE);
        // clear_req wins over a same-cycle request.
        w_accept    = req_valid && r_req_ready && !clear_req;
        w_rd_en     = w_accept && read_not_write && !w_err;
        if (r_state == ST_CLEAR) begin
            w_wr_en   = {BYTES_PER_WORD{1'b1}};
            w_base    = r_ptr[IDX_W-1:0];
            w_wr_data = {DATA_BUS_WIDTH{1'b0}};
        end else if (w_accept && !read_not_write && !w_err) begin
            w_wr_en   = byte_en;
            w_base    = address[IDX_W-1:0];
            w_wr_data = write_data;
        end else begin
            w_wr_en   = {BYTES_PER_WORD{1'b0}};
            w_base    = address[IDX_W-1:0];
            w_wr_data = write_data;
        end
    end

    // Clear/run controller with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_ptr       <= {PTR_W{1'b0}};
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_err;
            case (r_state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        r_ptr <= {PTR_W{1'b0}};
                    end else if (r_ptr == LAST_PTR) begin
                        r_state     <= ST_RUN;
                        r_ptr       <= {PTR_W{1'b0}};
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + PTR_STEP;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_ptr       <= {PTR_W{1'b0}};
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_ptr       <= {PTR_W{1'b0}};
                    r_req_ready <= 1'b0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

    data_ram_bytelane_byte_array #(
        .NUM_BYTES      (NUM_BYTES),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .IDX_W          (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_base    (w_base),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (read_data)
    );

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_ram_bytelane.sv
// ---------------------------------------------------------------------------
// tb_data_ram_bytelane
// Two instances: 16-bit/64-byte and 32-bit/128-byte. Only the selected one
// receives requests; its outputs are compared every cycle against a byte-array
// reference model with a clear countdown.
// ---------------------------------------------------------------------------
module tb_data_ram_bytelane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        valid;
    logic        rnw;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        cfg;

    logic        rdy16, val16, err16, busy16;
    logic [15:0] rd16;
    logic        rdy32, val32, err32, busy32;
    logic [31:0] rd32;

    logic        obs_ready, obs_valid, obs_err, obs_busy;
    logic [31:0] obs_rdata;

    int          checks;
    int          errors;
    logic [7:0]  m [128];
    logic [31:0] m_rdata;
    int          clear_left;
    int          bpw;
    int          nb;

    always #5 clk = ~clk;

    data_ram_bytelane #(
        .DATA_BUS_WIDTH    (16),
        .ADDRESS_BUS_WIDTH (16),
        .NUM_BYTES         (64)
    ) dut16 (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_req      (clr & ~cfg),
        .req_valid      (valid & ~cfg),
        .req_ready      (rdy16),
        .read_not_write (rnw),
        .address        (addr),
        .byte_en        (be[1:0]),
        .write_data     (wd[15:0]),
        .rsp_valid      (val16),
        .rsp_err        (err16),
        .read_data      (rd16),
        .busy           (busy16)
    );

    data_ram_bytelane #(
        .DATA_BUS_WIDTH    (32),
        .ADDRESS_BUS_WIDTH (16),
        .NUM_BYTES         (128)
    ) dut32 (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_req      (clr & cfg),
        .req_valid      (valid & cfg),
        .req_ready      (rdy32),
        .read_not_write (rnw),
        .address        (addr),
        .byte_en        (be),
        .write_data     (wd),
        .rsp_valid      (val32),
        .rsp_err        (err32),
        .read_data      (rd32),
        .busy           (busy32)
    );

    assign obs_ready = cfg ? rdy32  : rdy16;
    assign obs_valid = cfg ? val32  : val16;
    assign obs_err   = cfg ? err32  : err16;
    assign obs_busy  = cfg ? busy32 : busy16;
    assign obs_rdata = cfg ? rd32   : {16'h0000, rd16};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg=%0d got=%h exp=%h t=%0t", tag, cfg, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(obs_busy),  32'd1);
        chk({tag, "_ready"}, 32'(obs_ready), 32'd0);
        chk({tag, "_valid"}, 32'(obs_valid), 32'd0);
        chk({tag, "_err"},   32'(obs_err),   32'd0);
        chk({tag, "_rdata"}, obs_rdata,      32'd0);
    endtask

    // One clock cycle: drive at negedge, model, check just after posedge.
    task automatic cycle(input bit v, input bit r, input int a, input logic [3:0] b,
                         input logic [31:0] d, input bit c);
        bit acc;
        bit err;
        valid = v; rnw = r; addr = a[15:0]; be = b; wd = d; clr = c;
        acc = v && (clear_left == 0) && !c;
        err = (a + bpw - 1) > (nb - 1);
        if (acc && !err) begin
            if (r) begin
                m_rdata = 32'd0;
                for (int i = 0; i < bpw; i++) m_rdata[8*i +: 8] = m[a + i];
            end else begin
                for (int i = 0; i < bpw; i++) if (b[i]) m[a + i] = d[8*i +: 8];
            end
        end
        @(posedge clk);
        #1;
        if (c) begin
            clear_left = nb / bpw;
            for (int i = 0; i < 128; i++) m[i] = 8'h00;
        end else if (clear_left > 0) begin
            clear_left--;
        end
        chk("rsp_valid", 32'(obs_valid), 32'(acc));
        chk("rsp_err",   32'(obs_err),   32'(acc && err));
        chk("read_data", obs_rdata,      m_rdata);
        chk("busy",      32'(obs_busy),  32'(clear_left > 0));
        chk("req_ready", 32'(obs_ready), 32'(clear_left == 0));
        @(negedge clk);
        valid = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic rd(input int a);
        cycle(1'b1, 1'b1, a, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [3:0] b, input logic [31:0] d);
        cycle(1'b1, 1'b0, a, b, d, 1'b0);
    endtask

    // Count busy cycles until the clear ends (bounded).
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (obs_busy === 1'b1 && n < 1000) begin
            idle();
            n++;
        end
        chk(tag, 32'(n), 32'(nb / bpw));
    endtask

    task automatic run_suite(input bit c);
        cfg = c;
        bpw = c ? 4 : 2;
        nb  = c ? 128 : 64;
        valid = 1'b0; clr = 1'b0; rnw = 1'b0; addr = 16'h0; be = 4'h0; wd = 32'h0;
        rst_n = 1'b0;
        #1;
        // Garbage in the array before the clear.
        if (c) begin
            for (int i = 0; i < 128; i++) dut32.u_array.r_mem[i] = 8'($urandom);
        end else begin
            for (int i = 0; i < 64; i++) dut16.u_array.r_mem[i] = 8'($urandom);
        end
        chk_reset_outputs("reset");
        for (int i = 0; i < 128; i++) m[i] = 8'h00;
        m_rdata    = 32'd0;
        clear_left = nb / bpw;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clear_len");

        rd(0);
        rd(nb - bpw);
        if (!c) chk("plan_read62", obs_rdata, 32'h0000_0000);

        wr(16, 4'b0011, 32'h0000_BEEF);
        rd(16);
        if (!c) chk("plan_beef", obs_rdata, 32'h0000_BEEF);
        wr(16, 4'b0010, 32'h0000_1234);
        rd(16);
        if (!c) chk("plan_12ef", obs_rdata, 32'h0000_12EF);

        wr(33, 4'b0011, 32'h0000_A55A);
        rd(33);
        if (!c) chk("plan_a55a", obs_rdata, 32'h0000_A55A);
        rd(32);
        if (!c) chk("plan_5a00", obs_rdata, 32'h0000_5A00);

        wr(nb - 1, 4'hF, 32'hFFFF_FFFF);
        chk("top_byte_err", 32'(obs_err), 32'd1);
        rd(nb - bpw);
        wr(nb - bpw, 4'hF, 32'h8765_4321);
        rd(nb - bpw);
        wr(nb - bpw + 1, 4'hF, 32'h1111_1111);
        rd(nb - bpw);
        rd(200);
        chk("read200_err", 32'(obs_err), 32'd1);

        for (int k = 0; k < 400; k++) begin
            int a;
            if ($urandom_range(0, 9) == 0) a = int'($urandom_range(0, 65535));
            else                           a = int'($urandom_range(0, nb + 3));
            cycle($urandom_range(0, 4) != 0, 1'($urandom), a, 4'($urandom),
                  $urandom, $urandom_range(0, 149) == 0);
        end
        while (clear_left > 0) idle();

        wr(4, 4'hF, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 4, 4'h0, 32'h0, 1'b1);
        chk("clr_read_dropped", 32'(obs_valid), 32'd0);
        wait_clear("clear_req_len");
        rd(4);
        chk("after_clear_zero", obs_rdata, 32'h0);

        wr(8, 4'hF, 32'hC3C3_5AA5);
        rd(8);
        cycle(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) idle();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_clear_reset");
        m_rdata    = 32'd0;
        clear_left = nb / bpw;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("reset_clear_len");
        rd(8);
        chk("after_reset_zero", obs_rdata, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        cfg    = 1'b0;
        valid  = 1'b0;
        clr    = 1'b0;
        rnw    = 1'b0;
        addr   = 16'h0;
        be     = 4'h0;
        wd     = 32'h0;
        @(negedge clk);
        run_suite(1'b0);
        run_suite(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
